prv_trap_sequencer: RTL and testbench

- Privilege-side trap engine, the other end of the hazard unit's privilege interface.
- Consumes exception/return notifications and the pipe_clear handshake from the pipeline.
- Raises intr for pending enabled interrupts.
- Captures mepc/mcause/mtval and drives insert_pc/priv_pc to redirect fetch to the trap vector or back to mepc.
- Owns mstatus.MIE/MPIE sequencing.

---
 rtl/prv_trap_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_prv_trap_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prv_trap_sequencer.sv
// Privilege-side trap engine: takes exception/interrupt/mret events from the
// pipeline, captures mepc/mcause/mtval, and redirects fetch with a one-cycle
// insert_pc strobe once the pipeline is drained (or a drain timeout expires).
module prv_trap_sequencer #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned CLEAR_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fault_insn,
  input  logic            mal_insn,
  input  logic            illegal_insn,
  input  logic            fault_l,
  input  logic            mal_l,
  input  logic            fault_s,
  input  logic            mal_s,
  input  logic            breakpoint,
  input  logic            env,
  input  logic            ex_rmgmt,
  input  logic [XLEN-1:0] ex_rmgmt_cause,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] badaddr,
  input  logic            ret,
  input  logic            pipe_clear,
  input  logic            wb_enable,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            mie_ext,
  input  logic            mie_sw,
  input  logic            mie_timer,
  input  logic [XLEN-1:0] mtvec,
  output logic            intr,
  output logic            insert_pc,
  output logic [XLEN-1:0] priv_pc,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic            clear_timeout_err
);

  localparam int unsigned CntW = (CLEAR_TIMEOUT > 2) ? $clog2(CLEAR_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLEAR_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWaitClear, StInsert, StRet} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hold_epc_q, hold_epc_d;
  logic [XLEN-1:0] hold_cause_q, hold_cause_d;
  logic [XLEN-1:0] hold_tval_q, hold_tval_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            err_q, err_d;

  logic            exc_any;
  logic [XLEN-1:0] exc_cause;
  logic            exc_has_addr;
  logic            irq_any;
  logic [XLEN-1:0] irq_cause;
  logic            irq_window;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_code;

  assign exc_any = |{fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
                     breakpoint, env, ex_rmgmt};

  // Fixed-priority exception cause encode; address-type causes report badaddr.
  always_comb begin
    exc_cause    = '0;
    exc_has_addr = 1'b0;
    if (mal_insn) begin
      exc_cause = XLEN'(0);  exc_has_addr = 1'b1;
    end else if (fault_insn) begin
      exc_cause = XLEN'(1);  exc_has_addr = 1'b1;
    end else if (illegal_insn) begin
      exc_cause = XLEN'(2);
    end else if (breakpoint) begin
      exc_cause = XLEN'(3);
    end else if (env) begin
      exc_cause = XLEN'(11);
    end else if (mal_l) begin
      exc_cause = XLEN'(4);  exc_has_addr = 1'b1;
    end else if (mal_s) begin
      exc_cause = XLEN'(6);  exc_has_addr = 1'b1;
    end else if (fault_l) begin
      exc_cause = XLEN'(5);  exc_has_addr = 1'b1;
    end else if (fault_s) begin
      exc_cause = XLEN'(7);  exc_has_addr = 1'b1;
    end else if (ex_rmgmt) begin
      exc_cause = ex_rmgmt_cause;  exc_has_addr = 1'b1;
    end
  end

  // Interrupt cause encode: external > software > timer, MSB marks interrupt.
  always_comb begin
    irq_any   = 1'b1;
    irq_cause = '0;
    if (irq_ext && mie_ext) begin
      irq_cause = {1'b1, (XLEN-1)'(11)};
    end else if (irq_sw && mie_sw) begin
      irq_cause = {1'b1, (XLEN-1)'(3)};
    end else if (irq_timer && mie_timer) begin
      irq_cause = {1'b1, (XLEN-1)'(7)};
    end else begin
      irq_any = 1'b0;
    end
  end

  assign intr = (state_q == StIdle) && !exc_any && mie_q && irq_any;
  // A stalled, non-drained pipe never takes an interrupt; pipe_clear already implies this.
  assign irq_window = wb_enable || pipe_clear;

  assign vec_base = {mtvec[XLEN-1:2], 2'b00};

  // Interrupt code without the MSB, scaled by 4 for vectored dispatch.
  always_comb begin
    vec_code          = hold_cause_q;
    vec_code[XLEN-1]  = 1'b0;
    vec_code          = vec_code << 2;
  end

  // Next-state, CSR sequencing and redirect outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    hold_epc_d   = hold_epc_q;
    hold_cause_d = hold_cause_q;
    hold_tval_d  = hold_tval_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    mie_d        = mie_q;
    mpie_d       = mpie_q;
    err_d        = err_q;
    insert_pc    = 1'b0;
    priv_pc      = '0;
    unique case (state_q)
      StIdle: begin
        if (exc_any) begin
          hold_epc_d   = epc;
          hold_cause_d = exc_cause;
          hold_tval_d  = exc_has_addr ? badaddr : '0;
          state_d      = pipe_clear ? StInsert : StWaitClear;
        end else if (intr && pipe_clear && irq_window) begin
          hold_epc_d   = epc;
          hold_cause_d = irq_cause;
          hold_tval_d  = '0;
          state_d      = StInsert;
        end else if (ret) begin
          state_d = StRet;
        end
      end
      StWaitClear: begin
        cnt_d = cnt_q + 1'b1;
        if (pipe_clear) begin
          state_d = StInsert;
        end else if (cnt_q == CntLast) begin
          state_d = StInsert;
          err_d   = 1'b1;
        end
      end
      StInsert: begin
        insert_pc = 1'b1;
        priv_pc   = vec_base;
        if (hold_cause_q[XLEN-1] && (mtvec[1:0] == 2'b01)) begin
          priv_pc = vec_base + vec_code;
        end
        mepc_d   = hold_epc_q;
        mcause_d = hold_cause_q;
        mtval_d  = hold_tval_q;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        state_d  = StIdle;
      end
      StRet: begin
        insert_pc = 1'b1;
        priv_pc   = mepc_q;
        mie_d     = mpie_q;
        mpie_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and CSR registers; reset abandons any in-flight trap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_epc_q   <= '0;
      hold_cause_q <= '0;
      hold_tval_q  <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_epc_q   <= hold_epc_d;
      hold_cause_q <= hold_cause_d;
      hold_tval_q  <= hold_tval_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      err_q        <= err_d;
    end
  end

  assign mepc_o            = mepc_q;
  assign mcause_o          = mcause_q;
  assign mtval_o           = mtval_q;
  assign mstatus_mie       = mie_q;
  assign mstatus_mpie      = mpie_q;
  assign clear_timeout_err = err_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: expected redirects are queued when a trap/ret is
// driven and checked when insert_pc fires; CSRs are checked on the following cycle.
module tb_prv_trap_sequencer;

  localparam int unsigned XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic            fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic            breakpoint, env, ex_rmgmt;
  logic [XLEN-1:0] ex_rmgmt_cause, epc, badaddr, mtvec;
  logic            ret, pipe_clear, wb_enable;
  logic            irq_ext, irq_sw, irq_timer, mie_ext, mie_sw, mie_timer;
  logic            intr, insert_pc, mstatus_mie, mstatus_mpie, clear_timeout_err;
  logic [XLEN-1:0] priv_pc, mepc_o, mcause_o, mtval_o;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            trap;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [XLEN-1:0] model_mepc = '0;

  always #5 CLK = ~CLK;

  prv_trap_sequencer #(.XLEN(XLEN), .CLEAR_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env(env), .ex_rmgmt(ex_rmgmt),
    .ex_rmgmt_cause(ex_rmgmt_cause), .epc(epc), .badaddr(badaddr),
    .ret(ret), .pipe_clear(pipe_clear), .wb_enable(wb_enable),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .mie_ext(mie_ext), .mie_sw(mie_sw), .mie_timer(mie_timer),
    .mtvec(mtvec), .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .clear_timeout_err(clear_timeout_err)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_flags();
    {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
    {breakpoint, env, ex_rmgmt, ret} = '0;
  endtask

  task automatic push_trap(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                           input logic [XLEN-1:0] e, input logic [XLEN-1:0] tval);
    sb.push_back('{pc: pc, trap: 1'b1, cause: cause, epc: e, tval: tval});
    model_mepc = e;
  endtask

  task automatic push_ret();
    sb.push_back('{pc: model_mepc, trap: 1'b0, cause: '0, epc: '0, tval: '0});
  endtask

  // Scoreboard monitor: pop on each redirect, verify CSRs one cycle later.
  initial begin
    exp_t cur;
    exp_t pend;
    logic csr_pending = 1'b0;
    logic prev_ins    = 1'b0;
    forever begin
      @(negedge CLK);
      if (csr_pending) begin
        check("mepc", mepc_o, pend.epc);
        check("mcause", mcause_o, pend.cause);
        check("mtval", mtval_o, pend.tval);
        check("mie_after_trap", XLEN'(mstatus_mie), '0);
        csr_pending = 1'b0;
      end
      if (insert_pc) begin
        check("insert_single_cycle", XLEN'(prev_ins), '0);
        if (sb.size() == 0) begin
          check("unexpected_insert", XLEN'(1), '0);
        end else begin
          cur = sb.pop_front();
          check("priv_pc", priv_pc, cur.pc);
          if (cur.trap) begin
            pend        = cur;
            csr_pending = 1'b1;
          end
        end
      end
      prev_ins = insert_pc;
    end
  end

  initial begin
    int seen;
    RST = 1'b1;
    clear_flags();
    ex_rmgmt_cause = '0; epc = '0; badaddr = '0; mtvec = 32'h8000;
    pipe_clear = 1'b1; wb_enable = 1'b1;
    {irq_ext, irq_sw, irq_timer, mie_ext, mie_sw, mie_timer} = '0;
    tick(); tick();
    RST = 1'b0;
    check("rst_intr", XLEN'(intr), '0);
    check("rst_insert", XLEN'(insert_pc), '0);
    check("rst_mie", XLEN'(mstatus_mie), '0);
    check("rst_mpie", XLEN'(mstatus_mpie), 1);
    check("rst_err", XLEN'(clear_timeout_err), '0);
    check("rst_priv_pc", priv_pc, '0);
    check("rst_mepc", mepc_o, '0);
    check("rst_mcause", mcause_o, '0);
    check("rst_mtval", mtval_o, '0);

    // mret from reset state enables interrupts (MPIE=1).
    ret = 1'b1; push_ret();
    tick(); ret = 1'b0;
    check("ret0_insert", XLEN'(insert_pc), 1);
    tick();
    check("ret0_mie", XLEN'(mstatus_mie), 1);

    // Illegal instruction, pipe already clear: one-cycle latency.
    illegal_insn = 1'b1; epc = 32'h100; badaddr = 32'hDEAD; mtvec = 32'h8000;
    push_trap(32'h8000, 32'd2, 32'h100, '0);
    tick(); clear_flags();
    check("illegal_latency", XLEN'(insert_pc), 1);
    tick();
    check("illegal_mpie", XLEN'(mstatus_mpie), 1);
    tick();

    // mret back to mepc restores MIE.
    ret = 1'b1; push_ret();
    tick(); ret = 1'b0;
    check("ret1_insert", XLEN'(insert_pc), 1);
    tick();
    check("ret1_mie", XLEN'(mstatus_mie), 1);
    check("ret1_mpie", XLEN'(mstatus_mpie), 1);

    // Vectored timer interrupt.
    irq_timer = 1'b1; mie_timer = 1'b1; mtvec = 32'h8001; epc = 32'h200;
    #1;
    check("intr_timer", XLEN'(intr), 1);
    push_trap(32'h801C, 32'h8000_0007, 32'h200, '0);
    tick(); irq_timer = 1'b0; mie_timer = 1'b0;
    check("irq_latency", XLEN'(insert_pc), 1);
    tick(); tick();
    check("intr_masked", XLEN'(intr), '0);

    // Two load/store faults held while pipe is busy; mal_l wins.
    mal_l = 1'b1; fault_s = 1'b1; pipe_clear = 1'b0;
    epc = 32'h300; badaddr = 32'hBAD0; mtvec = 32'h8000;
    push_trap(32'h8000, 32'd4, 32'h300, 32'hBAD0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (insert_pc) seen++;
    end
    clear_flags(); pipe_clear = 1'b1;
    check("wait_no_early_insert", XLEN'(seen), '0);
    tick();
    check("wait_insert", XLEN'(insert_pc), 1);
    tick(); tick();
    check("no_timeout_err", XLEN'(clear_timeout_err), '0);

    // Drain timeout: redirect forced in cycle 17 after the flag.
    fault_l = 1'b1; pipe_clear = 1'b0; epc = 32'h400; badaddr = 32'h1234;
    push_trap(32'h8000, 32'd5, 32'h400, 32'h1234);
    tick(); clear_flags();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (insert_pc) seen++;
    end
    check("timeout_no_early_insert", XLEN'(seen), '0);
    tick();
    check("timeout_insert", XLEN'(insert_pc), 1);
    check("timeout_err_set", XLEN'(clear_timeout_err), 1);
    pipe_clear = 1'b1;
    tick(); tick(); tick();
    check("timeout_err_sticky", XLEN'(clear_timeout_err), 1);

    // ret and breakpoint together: trap wins, ret dropped.
    breakpoint = 1'b1; ret = 1'b1; epc = 32'h500; badaddr = 32'h77;
    push_trap(32'h8000, 32'd3, 32'h500, '0);
    tick(); clear_flags();
    check("bp_insert", XLEN'(insert_pc), 1);
    tick();
    check("bp_ret_dropped", XLEN'(insert_pc), '0);
    tick(); tick();

    // Reset mid-trap abandons it without touching the CSRs.
    fault_l = 1'b1; pipe_clear = 1'b0; badaddr = 32'h999;
    tick(); clear_flags();
    RST = 1'b1;
    tick();
    RST = 1'b0; pipe_clear = 1'b1;
    check("rst_mid_mcause", mcause_o, '0);
    check("rst_mid_err", XLEN'(clear_timeout_err), '0);
    tick();
    check("rst_mid_no_insert", XLEN'(insert_pc), '0);
    tick(); tick();
    check("sb_drained", XLEN'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
